main_mem_ctrl: RTL and testbench



---
 rtl/main_mem_ctrl_if.sv | 22 ++
 rtl/main_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_main_mem_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_ctrl_if.sv
// Request/response bundle between the cache controller (master) and the
// main-memory controller (slave).
interface main_mem_ctrl_if;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_read_req;
  logic         mem_write_req;
  logic [511:0] mem_rdata;
  logic         mem_ready;
  logic         mem_err;
  logic         busy;

  modport master (
    output mem_addr, mem_wdata, mem_read_req, mem_write_req,
    input  mem_rdata, mem_ready, mem_err, busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read_req, mem_write_req,
    output mem_rdata, mem_ready, mem_err, busy
  );
endinterface

// File: rtl/main_mem_ctrl.sv
// Word-organised main memory behind the cache controller: 512-bit line reads
// filled one word per cycle after a fixed latency, single-word writes.
module main_mem_ctrl #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LATENCY   = 4,
  parameter logic [31:0] INIT_WORD = 32'hFFFF_FFFF
) (
  input  logic           clk,
  input  logic           rst,
  main_mem_ctrl_if.slave mem_io
);

  localparam int unsigned CntW  = $clog2(LATENCY + 16);
  localparam int unsigned LineW = ADDR_W - 4;

  typedef enum logic [2:0] {StIdle, StWait, StFill, StWrite, StDone, StGap} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               op_rd_q, op_rd_d;
  logic               err_q, err_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]  word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [511:0]       rdata_q, rdata_d;
  logic               mem_we;

  // Storage is never reset; it powers up holding INIT_WORD everywhere.
  logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};

  logic unused_addr;
  assign unused_addr = ^mem_io.mem_addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    err_d   = err_q;
    line_d  = line_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Read has priority; a concurrent write stays pending at the requester.
        if (mem_io.mem_read_req) begin
          line_d  = mem_io.mem_addr[ADDR_W+1:6];
          err_d   = |mem_io.mem_addr[31:ADDR_W+2];
          op_rd_d = 1'b1;
          cnt_d   = '0;
          state_d = StWait;
        end else if (mem_io.mem_write_req) begin
          word_d  = mem_io.mem_addr[ADDR_W+1:2];
          wdata_d = mem_io.mem_wdata;
          err_d   = |mem_io.mem_addr[31:ADDR_W+2];
          op_rd_d = 1'b0;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = op_rd_q ? StFill : StWrite;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFill: begin
        rdata_d[{cnt_q[3:0], 5'd0} +: 32] = mem_q[{line_q, cnt_q[3:0]}];
        if (cnt_q[3:0] == 4'd15) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrite: begin
        mem_we  = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_rd_q <= 1'b0;
      err_q   <= 1'b0;
      line_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      err_q   <= err_d;
      line_q  <= line_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[word_q] <= wdata_q;
    end
  end

  assign mem_io.mem_rdata = rdata_q;
  assign mem_io.mem_ready = (state_q == StDone);
  assign mem_io.mem_err   = (state_q == StDone) && err_q;
  assign mem_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: the driver queues expected completions,
// a negedge monitor pops and checks each mem_ready pulse.
module tb_main_mem_ctrl;
  localparam int LAT = 4;

  typedef struct {
    bit           is_rd;
    logic [511:0] line;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pushed = 0;
  int   n_ready = 0;
  exp_t sb[$];

  main_mem_ctrl_if bus ();

  main_mem_ctrl #(
    .DEPTH    (4096),
    .ADDR_W   (12),
    .LATENCY  (LAT),
    .INIT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .mem_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.mem_ready) begin
      n_ready++;
      if (sb.size() == 0) begin
        timeout("unexpected_ready");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_cycle", 512'(cyc), 512'(e.cyc));
        check("mem_err", 512'(bus.mem_err), 512'(e.err));
        if (e.is_rd) check("rdata", bus.mem_rdata, e.line);
      end
    end
  end

  function automatic logic [511:0] set_word(input logic [511:0] l, input int k,
                                            input logic [31:0] v);
    logic [511:0] r;
    r = l;
    r[k*32 +: 32] = v;
    return r;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("idle");
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!bus.mem_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout(name);
  endtask

  // Issue one op at a negedge with the DUT idle; hold req until mem_ready
  // (plus hold_extra cycles), scrambling addr/wdata after acceptance.
  task automatic issue(input bit is_rd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [511:0] line, input logic err, input int hold_extra);
    exp_t e;
    wait_idle();
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    if (is_rd) bus.mem_read_req = 1'b1;
    else       bus.mem_write_req = 1'b1;
    e.is_rd = is_rd;
    e.line  = line;
    e.err   = err;
    e.cyc   = cyc + 1 + (is_rd ? LAT + 16 : LAT + 1);
    sb.push_back(e);
    n_pushed++;
    @(negedge clk);
    bus.mem_addr  = $urandom;
    bus.mem_wdata = $urandom;
    wait_ready(is_rd ? "read_ready" : "write_ready");
    repeat (hold_extra) @(negedge clk);
    bus.mem_read_req  = 1'b0;
    bus.mem_write_req = 1'b0;
  endtask

  initial begin
    logic [511:0] all_f;
    logic [511:0] l_exp;
    exp_t e;

    all_f             = {16{32'hFFFF_FFFF}};
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_read_req  = 1'b0;
    bus.mem_write_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 512'(bus.busy), 512'(0));
    check("rst_ready", 512'(bus.mem_ready), 512'(0));
    check("rst_err", 512'(bus.mem_err), 512'(0));
    check("rst_rdata", bus.mem_rdata, '0);

    // Fresh read: all init words; busy drops two cycles after ready.
    issue(1'b1, 32'h0000_0040, '0, all_f, 1'b0, 0);
    @(negedge clk);
    check("busy_in_gap", 512'(bus.busy), 512'(1));
    @(negedge clk);
    check("busy_after_gap", 512'(bus.busy), 512'(0));

    issue(1'b0, 32'h0000_0044, 32'hDEAD_BEEF, '0, 1'b0, 0);
    issue(1'b1, 32'h0000_0040, '0, set_word(all_f, 1, 32'hDEAD_BEEF), 1'b0, 0);

    l_exp = '0;
    for (int k = 0; k < 16; k++) begin
      issue(1'b0, 32'h80 + 32'(4 * k), 32'h100 + 32'(k), '0, 1'b0, 0);
      l_exp = set_word(l_exp, k, 32'h100 + 32'(k));
    end
    issue(1'b1, 32'h0000_0080, '0, l_exp, 1'b0, 0);
    // Out-of-range, unaligned read wraps onto the same line.
    issue(1'b1, 32'h0001_00BC, '0, l_exp, 1'b1, 0);

    // Simultaneous read and write: read first, held write after GAP.
    wait_idle();
    bus.mem_addr      = 32'h0;
    bus.mem_wdata     = 32'h1234_5678;
    bus.mem_read_req  = 1'b1;
    bus.mem_write_req = 1'b1;
    e.is_rd = 1'b1; e.line = all_f; e.err = 1'b0; e.cyc = cyc + 1 + LAT + 16;
    sb.push_back(e);
    e.is_rd = 1'b0; e.line = '0; e.cyc = e.cyc + 8;
    sb.push_back(e);
    n_pushed += 2;
    @(negedge clk);
    wait_ready("dual_read");
    bus.mem_read_req = 1'b0;
    @(negedge clk);
    wait_ready("dual_write");
    bus.mem_write_req = 1'b0;

    issue(1'b0, 32'h0001_0004, 32'hCAFE_F00D, '0, 1'b1, 0);
    l_exp = set_word(set_word(all_f, 0, 32'h1234_5678), 1, 32'hCAFE_F00D);
    // Read req held one cycle past ready must not be re-serviced.
    issue(1'b1, 32'h0000_0000, '0, l_exp, 1'b0, 1);
    repeat (3) @(negedge clk);
    check("no_reservice_busy", 512'(bus.busy), 512'(0));

    // Reset during WAIT discards the write and clears outputs.
    wait_idle();
    bus.mem_addr      = 32'h0000_0008;
    bus.mem_wdata     = 32'h55AA_55AA;
    bus.mem_write_req = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_in_wait", 512'(bus.busy), 512'(1));
    rst = 1'b1;
    bus.mem_write_req = 1'b0;
    @(negedge clk);
    check("midrst_busy", 512'(bus.busy), 512'(0));
    check("midrst_ready", 512'(bus.mem_ready), 512'(0));
    check("midrst_rdata", bus.mem_rdata, '0);
    rst = 1'b0;
    issue(1'b1, 32'h0000_0000, '0, l_exp, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("ready_pulses", 512'(n_ready), 512'(n_pushed));
    check("sb_empty", 512'(sb.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
